// File: rtl/myproject_mac_pipe.sv
// myproject_mac_pipe: pipelined signed multiply-accumulate with saturating accumulator and valid/ready handshake.
module myproject_mac_pipe #(
    parameter int din0_WIDTH  = 16,
    parameter int din1_WIDTH  = 15,
    parameter int DIN1_SIGNED = 0,
    parameter int NUM_STAGE   = 3,
    parameter int ACC_WIDTH   = 32,
    parameter int dout_WIDTH  = 28
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  acc_first,
    input  logic                  acc_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);
    localparam int PW = din0_WIDTH + din1_WIDTH + 1;
    localparam int SW = (ACC_WIDTH > PW ? ACC_WIDTH : PW) + 1;
    localparam int L = NUM_STAGE - 1;
    logic                         en;
    logic signed [din1_WIDTH:0]   d1x;
    logic signed [PW-1:0]         a, b, prod;
    logic signed [PW-1:0]         p [NUM_STAGE];
    logic [NUM_STAGE-1:0]         v, f, l;
    logic signed [ACC_WIDTH-1:0]  acc, acc_nxt;
    logic signed [SW-1:0]         sum;
    logic [dout_WIDTH-1:0]        dsat;
    logic                         ovf_acc, ovf_nxt, sat_a, sat_d;
    assign en = !(out_valid && !out_ready);
    assign in_ready = en;
    assign d1x = DIN1_SIGNED != 0 ? {din1[din1_WIDTH-1], din1} : {1'b0, din1};
    assign a = PW'($signed(din0));
    assign b = PW'(d1x);
    assign prod = a * b;
    // Sum is kept wide enough for both operands so saturation sees the true value.
    always_comb begin
        sum = (f[L] ? '0 : SW'(acc)) + SW'(p[L]);
        sat_a = !(&sum[SW-1:ACC_WIDTH-1] || ~|sum[SW-1:ACC_WIDTH-1]);
        acc_nxt = sat_a ? {sum[SW-1], {(ACC_WIDTH-1){!sum[SW-1]}}} : sum[ACC_WIDTH-1:0];
        ovf_nxt = (f[L] ? 1'b0 : ovf_acc) | sat_a;
        sat_d = !(&acc_nxt[ACC_WIDTH-1:dout_WIDTH-1] || ~|acc_nxt[ACC_WIDTH-1:dout_WIDTH-1]);
        dsat = sat_d ? {acc_nxt[ACC_WIDTH-1], {(dout_WIDTH-1){!acc_nxt[ACC_WIDTH-1]}}} : acc_nxt[dout_WIDTH-1:0];
    end
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v <= '0;
            f <= '0;
            l <= '0;
            for (int i = 0; i < NUM_STAGE; i++) p[i] <= '0;
        end else if (en) begin
            v[0] <= in_valid;
            f[0] <= acc_first;
            l[0] <= acc_last;
            p[0] <= prod;
            for (int i = 1; i < NUM_STAGE; i++) begin
                v[i] <= v[i-1];
                f[i] <= f[i-1];
                l[i] <= l[i-1];
                p[i] <= p[i-1];
            end
        end
    end
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc <= '0;
            ovf_acc <= 1'b0;
            out_valid <= 1'b0;
            dout <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            out_valid <= v[L] && l[L];
            if (v[L] && l[L]) begin
                dout <= dsat;
                ovf <= ovf_nxt | sat_d;
                acc <= '0;
                ovf_acc <= 1'b0;
            end else if (v[L]) begin
                acc <= acc_nxt;
                ovf_acc <= ovf_nxt;
            end
        end
    end
endmodule

// File: tb/tb_myproject_mac_pipe.sv
// tb_myproject_mac_pipe: directed and random MAC checks against an arithmetic reference model.
module tb_myproject_mac_pipe;
    logic        ap_clk = 0, ap_rst_n = 0, in_valid = 0, acc_first = 0, acc_last = 0, out_ready = 1;
    logic [15:0] din0 = '0;
    logic [14:0] din1 = '0;
    logic        in_ready, out_valid, ovf, in_ready2, out_valid2, ovf2;
    logic [27:0] dout;
    logic [31:0] dout2;
    longint      m_acc, exp_d[$], exp_d2[$], held_d, last_d, last_d2;
    bit          m_ovf, exp_o[$], exp_o2[$], held_o, last_o, last_o2, stalled, last_acc;
    int          n_chk = 0, n_fail = 0, lat, nacc;

    myproject_mac_pipe dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .ovf(ovf)
    );
    myproject_mac_pipe #(.dout_WIDTH(32)) dut32 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
        .out_valid(out_valid2), .out_ready(out_ready), .dout(dout2), .ovf(ovf2)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint clamp(input longint x, input int w);
        longint mx = (longint'(1) << (w - 1)) - 1;
        return x > mx ? mx : (x < -mx - 1 ? -mx - 1 : x);
    endfunction

    task automatic model_beat();
        longint p = longint'($signed(din0)) * longint'(din1);
        longint s = acc_first ? p : m_acc + p;
        longint c = clamp(s, 32);
        m_ovf = (acc_first ? 1'b0 : m_ovf) | (c != s);
        m_acc = c;
        if (acc_last) begin
            exp_d.push_back(clamp(c, 28));
            exp_o.push_back(m_ovf | (clamp(c, 28) != c));
            exp_d2.push_back(c);
            exp_o2.push_back(m_ovf);
            m_acc = 0;
            m_ovf = 0;
        end
    endtask

    task automatic cyc();
        #1;
        last_acc = in_valid && in_ready;
        if (last_acc) model_beat();
        if (stalled) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_dout", $signed(dout), held_d);
            chk("hold_ovf", ovf, held_o);
        end
        stalled = out_valid && !out_ready;
        held_d = longint'($signed(dout));
        held_o = ovf;
        if (stalled) chk("in_ready_low", in_ready, 0);
        if (out_valid && out_ready) begin
            chk("result_expected", exp_d.size() != 0, 1);
            chk("valid_match", out_valid2, 1);
            if (exp_d.size() != 0) begin
                last_d = exp_d.pop_front();
                last_o = exp_o.pop_front();
                last_d2 = exp_d2.pop_front();
                last_o2 = exp_o2.pop_front();
                chk("dout", $signed(dout), last_d);
                chk("ovf", ovf, last_o);
                chk("dout32", $signed(dout2), last_d2);
                chk("ovf32", ovf2, last_o2);
            end
        end
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic beat(input logic [15:0] a, input logic [14:0] b, input logic fi, input logic la);
        in_valid = 1;
        din0 = a;
        din1 = b;
        acc_first = fi;
        acc_last = la;
        cyc();
        in_valid = 0;
    endtask

    task automatic drain();
        int k = 0;
        in_valid = 0;
        out_ready = 1;
        while (exp_d.size() != 0 && k < 40) begin
            cyc();
            k++;
        end
        chk("drain_empty", exp_d.size(), 0);
        cyc();
    endtask

    initial begin
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1;
        @(negedge ap_clk);
        // Latency and single-product result: -3 * 5
        beat(16'hFFFD, 15'd5, 1, 1);
        lat = 0;
        while (!out_valid && lat < 10) begin
            cyc();
            lat++;
        end
        chk("latency", lat + 1, 4);
        chk("dout_neg15", $signed(dout), -15);
        drain();
        chk("single_ovf", last_o, 0);
        // Extreme operands: dout saturation only in the narrow instance
        beat(16'h8000, 15'd32767, 1, 1);
        drain();
        chk("sat28_dout", last_d, -134217728);
        chk("sat28_ovf", last_o, 1);
        chk("w32_dout", last_d2, -1073709056);
        chk("w32_ovf", last_o2, 0);
        // Accumulator saturation then a clean result
        beat(16'd32767, 15'd32767, 1, 0);
        beat(16'd32767, 15'd32767, 0, 0);
        beat(16'd32767, 15'd32767, 0, 1);
        drain();
        chk("accsat_dout", last_d, 134217727);
        chk("accsat_ovf", last_o, 1);
        chk("accsat_dout32", last_d2, 2147483647);
        beat(16'd1, 15'd1, 0, 1);
        drain();
        chk("after_sat_dout", last_d, 1);
        chk("after_sat_ovf", last_o, 0);
        // Backpressure: inputs held until accepted
        out_ready = 0;
        nacc = 0;
        for (int c = 0; c < 14; c++) begin
            in_valid = 1;
            din0 = 16'(nacc + 1);
            din1 = 15'(nacc + 2);
            acc_first = 1;
            acc_last = 1;
            cyc();
            if (last_acc) nacc++;
        end
        chk("stall_accepted", nacc, 4);
        drain();
        // Random traffic with bubbles and random backpressure
        in_valid = 0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || last_acc) begin
                in_valid = $urandom_range(3) != 0;
                din0 = 16'($urandom);
                din1 = 15'($urandom);
                acc_first = $urandom_range(3) == 0;
                acc_last = $urandom_range(3) == 0;
            end
            out_ready = $urandom_range(3) != 0;
            cyc();
        end
        in_valid = 0;
        out_ready = 1;
        cyc();
        beat(16'd9, 15'd9, 0, 1);
        drain();
        // Asynchronous reset mid-accumulation with a result pending
        out_ready = 0;
        beat(16'd7, 15'd1, 1, 1);
        beat(16'd11, 15'd13, 1, 0);
        beat(16'd17, 15'd19, 0, 0);
        repeat (3) cyc();
        chk("pre_rst_valid", out_valid, 1);
        #2;
        ap_rst_n = 0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_dout", dout, 0);
        chk("async_ovf", ovf, 0);
        chk("async_in_ready", in_ready, 1);
        exp_d.delete();
        exp_o.delete();
        exp_d2.delete();
        exp_o2.delete();
        m_acc = 0;
        m_ovf = 0;
        stalled = 0;
        @(negedge ap_clk);
        ap_rst_n = 1;
        out_ready = 1;
        beat(16'd2, 15'd3, 1, 1);
        drain();
        chk("post_rst_dout", last_d, 6);
        chk("post_rst_ovf", last_o, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/myproject_mac_pipe.md
MYPROJECT_MAC_PIPE -- requirements
Module: myproject_mac_pipe

Interface
REQ-001 The block SHALL have parameter din0_WIDTH, default 16, width of multiplicand din0, which is always signed.
REQ-002 The block SHALL have parameter din1_WIDTH, default 15, width of multiplier din1.
REQ-003 The block SHALL have parameter DIN1_SIGNED, default 0, where 0 means din1 is zero-extended and 1 means din1 is sign-extended.
REQ-004 The block SHALL have parameter NUM_STAGE, default 3, legal range 1..4, the number of product pipeline registers.
REQ-005 The block SHALL have parameter ACC_WIDTH, default 32, the signed accumulator width; ACC_WIDTH >= dout_WIDTH is required.
REQ-006 The block SHALL have parameter dout_WIDTH, default 28, the signed result width.
REQ-007 The block SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-008 The block SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 The block SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat when in_valid && in_ready.
REQ-011 The block SHALL have port din0, input, din0_WIDTH bits: signed operand.
REQ-012 The block SHALL have port din1, input, din1_WIDTH bits: operand, signedness set by DIN1_SIGNED.
REQ-013 The block SHALL have port acc_first, input, 1 bit: this beat starts a new accumulation.
REQ-014 The block SHALL have port acc_last, input, 1 bit: this beat ends the accumulation and produces a result.
REQ-015 The block SHALL have port out_valid, output, 1 bit: dout/ovf hold a result.
REQ-016 The block SHALL have port out_ready, input, 1 bit: a result is consumed when out_valid && out_ready.
REQ-017 The block SHALL have port dout, output, dout_WIDTH bits: signed saturated accumulation result.
REQ-018 The block SHALL have port ovf, output, 1 bit: saturation occurred anywhere in this accumulation.

Function
REQ-019 The product SHALL be the exact signed product of din0 and extended din1, at din0_WIDTH+din1_WIDTH+1 bits, with no truncation.
REQ-020 The pipeline SHALL be NUM_STAGE product registers followed by one accumulator/output register; each stage carries a valid bit plus the acc_first/acc_last tags.
REQ-021 Global advance SHALL be en = !(out_valid && !out_ready); in_ready = en; when en=0 all stages and the accumulator hold.
REQ-022 Latency SHALL be: out_valid rises NUM_STAGE+1 en-cycles after the acceptance of an acc_last beat.
REQ-023 Accumulate, on a valid beat reaching the accumulator: next = acc_first ? product : acc + product, computed at ACC_WIDTH+1 bits, then saturated to the signed ACC_WIDTH range.
REQ-024 Any ACC_WIDTH saturation SHALL set sticky ovf_acc; acc_first SHALL reset ovf_acc to that beat's own saturation status.
REQ-025 On an acc_last beat, the block SHALL saturate the accumulator value to the signed dout_WIDTH range, set out_valid=1 and dout to that value, and set ovf = ovf_acc OR dout saturation; it SHALL then clear acc and ovf_acc to 0.
REQ-026 A beat with acc_first=acc_last=1 SHALL produce a single-product result.
REQ-027 A beat without acc_first following a completed result SHALL accumulate onto 0.
REQ-028 out_valid SHALL clear on the cycle after out_valid && out_ready unless a new acc_last beat lands in the same cycle, in which case dout/ovf update and out_valid stays 1.
REQ-029 Bubbles (in_valid=0) SHALL propagate as invalid stages and SHALL NOT modify acc.
REQ-030 dout and ovf SHALL be stable while out_valid && !out_ready.

Reset
REQ-031 ap_rst_n=0 SHALL immediately, asynchronously, clear all stage valid bits, acc, ovf_acc, out_valid, dout and ovf to 0.
REQ-032 While ap_rst_n=0, in_ready SHALL be 1; a partial accumulation in flight is discarded.
REQ-033 After ap_rst_n deasserts, the first accepted beat SHALL be processed normally.

Verification
REQ-034 Defaults, din0=16'hFFFD (-3), din1=5, first=last=1, out_ready=1 -> out_valid exactly 4 cycles later, dout=-15, ovf=0.
REQ-035 DIN1_SIGNED=0, din0=-32768, din1=32767, first=last=1 -> dout saturates to -134217728, ovf=1; with dout_WIDTH=32 -> dout=-1073709056, ovf=0.
REQ-036 Three beats of 32767*32767 (first, -, last) -> acc saturates at 2147483647, dout=134217727, ovf=1; the next single beat 1*1 -> dout=1, ovf=0.
REQ-037 Hold out_ready=0 for 5 cycles while in_valid=1 with a result pending -> in_ready=0, no beats lost or duplicated, dout stable; release -> results in order.
REQ-038 Assert ap_rst_n=0 mid-accumulation (2 of 4 beats accepted) -> out_valid=0 and dout=0 at once; a new first=last beat 2*3 -> dout=6.
